// File: rtl/crossbar_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : crossbar_3x3
//  Description : Registered 3-in / 3-out byte crossbar. Each output picks one
//                input through a 2-bit field of the select word. Only
//                one-to-one routings (permutations) are legal; an illegal
//                word zeroes every lane and clears valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module crossbar_3x3 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [5:0]       select,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic             valid
);

  localparam logic [1:0] C_SRC_ILLEGAL = 2'd3;

  logic [1:0]       w_s0;
  logic [1:0]       w_s1;
  logic [1:0]       w_s2;
  logic             w_in_range;
  logic             w_distinct;
  logic             w_legal;
  logic [WIDTH-1:0] w_mux0;
  logic [WIDTH-1:0] w_mux1;
  logic [WIDTH-1:0] w_mux2;

  logic [WIDTH-1:0] r_out0;
  logic [WIDTH-1:0] r_out1;
  logic [WIDTH-1:0] r_out2;
  logic             r_valid;

  assign w_s0 = select[1:0];
  assign w_s1 = select[3:2];
  assign w_s2 = select[5:4];

  // Legality depends only on the select word: every field in 0..2 and no two equal.
  always_comb begin
    w_in_range = (w_s0 != C_SRC_ILLEGAL) && (w_s1 != C_SRC_ILLEGAL) &&
                 (w_s2 != C_SRC_ILLEGAL);
    w_distinct = (w_s0 != w_s1) && (w_s0 != w_s2) && (w_s1 != w_s2);
    w_legal    = w_in_range && w_distinct;
  end

  // Per-lane source mux; illegal words force every lane to zero.
  always_comb begin
    w_mux0 = '0;
    w_mux1 = '0;
    w_mux2 = '0;
    if (w_legal) begin
      case (w_s0)
        2'd0:    w_mux0 = in0;
        2'd1:    w_mux0 = in1;
        2'd2:    w_mux0 = in2;
        default: w_mux0 = '0;
      endcase
      case (w_s1)
        2'd0:    w_mux1 = in0;
        2'd1:    w_mux1 = in1;
        2'd2:    w_mux1 = in2;
        default: w_mux1 = '0;
      endcase
      case (w_s2)
        2'd0:    w_mux2 = in0;
        2'd1:    w_mux2 = in1;
        2'd2:    w_mux2 = in2;
        default: w_mux2 = '0;
      endcase
    end
  end

  // Single output register stage; reset takes priority over the data path.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out0  <= '0;
      r_out1  <= '0;
      r_out2  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_out0  <= w_mux0;
      r_out1  <= w_mux1;
      r_out2  <= w_mux2;
      r_valid <= w_legal;
    end
  end

  assign out0  = r_out0;
  assign out1  = r_out1;
  assign out2  = r_out2;
  assign valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_crossbar_3x3.sv
`default_nettype none
// ============================================================================
//  Module      : tb_crossbar_3x3
//  Description : Self-checking directed bench for crossbar_3x3.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_crossbar_3x3;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic [5:0]       select;
  logic [WIDTH-1:0] out0;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             valid;

  int errors;
  int checks;

  crossbar_3x3 #(.WIDTH(WIDTH)) dut (
    .clk    (clk),
    .rst    (rst),
    .in0    (in0),
    .in1    (in1),
    .in2    (in2),
    .select (select),
    .out0   (out0),
    .out1   (out1),
    .out2   (out2),
    .valid  (valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the six legal codes listed explicitly.
  function automatic logic is_legal(input logic [5:0] s);
    case (s)
      6'b100100, 6'b011000, 6'b100001,
      6'b001001, 6'b010010, 6'b000110: is_legal = 1'b1;
      default:                         is_legal = 1'b0;
    endcase
  endfunction

  function automatic logic [WIDTH-1:0] pick(input logic [1:0] f,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] c);
    case (f)
      2'd0:    pick = a;
      2'd1:    pick = b;
      2'd2:    pick = c;
      default: pick = '0;
    endcase
  endfunction

  // Apply inputs, clock once, settle past the edge.
  task automatic drive_and_clock(input logic r, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b,
                                 input logic [WIDTH-1:0] c,
                                 input logic [5:0] s);
    rst = r; in0 = a; in1 = b; in2 = c; select = s;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_and_clock(1'b1, 8'hA5, 8'h3C, 8'hF0, 6'b100100);
    checks++;
    if ({out0, out1, out2, valid} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset: got %h/%h/%h v=%b, exp 00/00/00 v=0", out0, out1, out2, valid);
    end
  endtask

  task automatic test_identity();
    drive_and_clock(1'b0, 8'h11, 8'h22, 8'h33, {2'd2, 2'd1, 2'd0});
    checks++;
    if ({out0, out1, out2, valid} !== {8'h11, 8'h22, 8'h33, 1'b1}) begin
      errors++;
      $display("FAIL identity: got %h/%h/%h v=%b, exp 11/22/33 v=1", out0, out1, out2, valid);
    end
  endtask

  task automatic test_rotation();
    drive_and_clock(1'b0, 8'h11, 8'h22, 8'h33, {2'd0, 2'd2, 2'd1});
    checks++;
    if ({out0, out1, out2, valid} !== {8'h22, 8'h33, 8'h11, 1'b1}) begin
      errors++;
      $display("FAIL rotation: got %h/%h/%h v=%b, exp 22/33/11 v=1", out0, out1, out2, valid);
    end
    drive_and_clock(1'b0, 8'h11, 8'h22, 8'h33, {2'd1, 2'd0, 2'd2});
    checks++;
    if ({out0, out1, out2, valid} !== {8'h33, 8'h11, 8'h22, 1'b1}) begin
      errors++;
      $display("FAIL rotation2: got %h/%h/%h v=%b, exp 33/11/22 v=1", out0, out1, out2, valid);
    end
  endtask

  task automatic test_duplicate();
    drive_and_clock(1'b0, 8'h11, 8'h22, 8'h33, {2'd0, 2'd0, 2'd1});
    checks++;
    if ({out0, out1, out2, valid} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL duplicate: got %h/%h/%h v=%b, exp 00/00/00 v=0", out0, out1, out2, valid);
    end
    // Equal data on all lanes must still be rejected for an illegal word.
    drive_and_clock(1'b0, 8'h77, 8'h77, 8'h77, {2'd2, 2'd1, 2'd2});
    checks++;
    if ({out0, out1, out2, valid} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL dup_equal_data: got %h/%h/%h v=%b, exp 00/00/00 v=0", out0, out1, out2, valid);
    end
  endtask

  task automatic test_out_of_range();
    drive_and_clock(1'b0, 8'hDE, 8'hAD, 8'hBE, {2'd3, 2'd1, 2'd0});
    checks++;
    if ({out0, out1, out2, valid} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL out_of_range: got %h/%h/%h v=%b, exp 00/00/00 v=0", out0, out1, out2, valid);
    end
    drive_and_clock(1'b0, 8'hDE, 8'hAD, 8'hBE, {2'd0, 2'd2, 2'd3});
    checks++;
    if ({out0, out1, out2, valid} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL out_of_range_s0: got %h/%h/%h v=%b, exp 00/00/00 v=0", out0, out1, out2, valid);
    end
  endtask

  task automatic test_back_to_back_reset();
    drive_and_clock(1'b0, 8'hC1, 8'hC2, 8'hC3, {2'd0, 2'd1, 2'd2});
    checks++;
    if ({out0, out1, out2, valid} !== {8'hC3, 8'hC2, 8'hC1, 1'b1}) begin
      errors++;
      $display("FAIL pre_reset: got %h/%h/%h v=%b, exp C3/C2/C1 v=1", out0, out1, out2, valid);
    end
    drive_and_clock(1'b1, 8'hD1, 8'hD2, 8'hD3, {2'd2, 2'd1, 2'd0});
    checks++;
    if ({out0, out1, out2, valid} !== {8'h00, 8'h00, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset: got %h/%h/%h v=%b, exp 00/00/00 v=0", out0, out1, out2, valid);
    end
    drive_and_clock(1'b0, 8'hE1, 8'hE2, 8'hE3, {2'd1, 2'd2, 2'd0});
    checks++;
    if ({out0, out1, out2, valid} !== {8'hE1, 8'hE3, 8'hE2, 1'b1}) begin
      errors++;
      $display("FAIL post_reset: got %h/%h/%h v=%b, exp E1/E3/E2 v=1", out0, out1, out2, valid);
    end
  endtask

  task automatic test_sweep();
    logic [WIDTH-1:0] a, b, c;
    logic [WIDTH-1:0] e0, e1, e2;
    logic             ev;
    logic [5:0]       s;
    int               nvalid;
    for (int t = 0; t < 17; t++) begin
      case (t)
        0:       begin a = 8'h00; b = 8'h00; c = 8'h00; end
        1:       begin a = 8'h5A; b = 8'h5A; c = 8'h5A; end
        2:       begin a = 8'hFF; b = 8'hFF; c = 8'hFF; end
        3:       begin a = 8'h01; b = 8'h02; c = 8'h04; end
        default: begin
          a = WIDTH'($urandom); b = WIDTH'($urandom); c = WIDTH'($urandom);
        end
      endcase
      nvalid = 0;
      for (int k = 0; k < 128; k++) begin
        s = (k < 64) ? 6'(k) : 6'($urandom);
        drive_and_clock(1'b0, a, b, c, s);
        ev = is_legal(s);
        e0 = ev ? pick(s[1:0], a, b, c) : '0;
        e1 = ev ? pick(s[3:2], a, b, c) : '0;
        e2 = ev ? pick(s[5:4], a, b, c) : '0;
        if (k < 64 && valid === 1'b1) nvalid++;
        checks++;
        if ({out0, out1, out2, valid} !== {e0, e1, e2, ev}) begin
          errors++;
          $display("FAIL sweep t=%0d sel=%b: got %h/%h/%h v=%b, exp %h/%h/%h v=%b",
                   t, s, out0, out1, out2, valid, e0, e1, e2, ev);
        end
      end
      checks++;
      if (nvalid !== 6) begin
        errors++;
        $display("FAIL sweep_valid_count t=%0d: got %0d, exp 6", t, nvalid);
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1; in0 = '0; in1 = '0; in2 = '0; select = '0;
    #2;
    test_reset();
    test_identity();
    test_rotation();
    test_duplicate();
    test_out_of_range();
    test_back_to_back_reset();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/crossbar_3x3.md
# crossbar_3x3

Registered 3-input, 3-output, 8-bit crossbar switch. Each output independently selects one of the three input bytes through a 2-bit field of a 6-bit select word. A `valid` flag reports whether the select word describes a legal one-to-one routing (a permutation). The block sits between three byte-wide producers and three consumers in the datapath, and all outputs are registered on a single clock.

## Interface

Parameters:
- `WIDTH`, default 8: data width of every input and output lane.

Ports:
- `clk`, input, 1: the single clock; all state updates on the rising edge.
- `rst`, input, 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in0`, input, WIDTH: data lane 0.
- `in1`, input, WIDTH: data lane 1.
- `in2`, input, WIDTH: data lane 2.
- `select`, input, 6: routing word.
  - `[1:0]` is the source for `out0`.
  - `[3:2]` is the source for `out1`.
  - `[5:4]` is the source for `out2`.
- `out0`, output, WIDTH: routed lane 0, registered.
- `out1`, output, WIDTH: routed lane 1, registered.
- `out2`, output, WIDTH: routed lane 2, registered.
- `valid`, output, 1: the routing registered with the outputs was legal.

## Operation

- Field decode for each field `s` (`s0` = `select[1:0]`, `s1` = `select[3:2]`, `s2` = `select[5:4]`):
  - `0` selects `in0`.
  - `1` selects `in1`.
  - `2` selects `in2`.
  - `3` is illegal.
- Legal select word: all three fields are in 0..2 AND are pairwise distinct. Only 6 of the 64 codes are legal:
  - {s2,s1,s0} = {2,1,0}, {1,2,0}, {2,0,1}, {0,2,1}, {1,0,2}, {0,1,2}.
- Legal select word:
  - `valid` = 1.
  - `outK` = the input chosen by `sK`, for K = 0..2.
- Illegal select word, which covers any field = 3 or any two fields equal:
  - `valid` = 0.
  - `out0`, `out1` and `out2` are all driven to 0, including lanes whose own field is in range.
- Validity is decided from `select` alone. Data values never affect `valid`. Identical data on all inputs still yields `valid` = 0 for illegal words.
- Upper `select` bits beyond [5:0] do not exist. Stimulus wider than 6 bits is truncated by the driver, not by the block.
- Any X or Z on `select` is not required to be handled. Outputs in that case are unspecified until the next clean sample.

## Timing

- Latency is exactly 1 cycle. Inputs sampled at rising edge N appear on the outputs after edge N and hold until edge N+1.
- The block has no handshake. A new routing is accepted on every cycle, and the throughput is one word per clock.
- Reset:
  - When `rst` = 1 at a rising edge, `out0`, `out1` and `out2` become 0 and `valid` becomes 0, regardless of the inputs.
  - Reset has priority over the data path.
  - The first edge with `rst` = 0 loads the current inputs normally.
- Reset asserted mid-stream discards the word sampled at that edge. No value from before reset reappears afterwards.
- Output values between the start of simulation and the first reset edge are undefined.
- The decode and mux are purely combinational ahead of one output register stage. No other state exists.

## Test plan

- Reset: drive `rst` = 1 with `in0`/`in1`/`in2` = A5/3C/F0 and `select` = 6'b100100, then clock once. Require `out0`/`out1`/`out2` = 00/00/00 and `valid` = 0.
- Identity route: `rst` = 0, `in0`/`in1`/`in2` = 11/22/33, `select` = {2,1,0}. After one edge, require `out0`/`out1`/`out2` = 11/22/33 and `valid` = 1.
- Rotation route: `in0`/`in1`/`in2` = 11/22/33, `select` = {0,2,1}. Require `out0`/`out1`/`out2` = 22/33/11 and `valid` = 1.
- Duplicate field: `in0`/`in1`/`in2` = 11/22/33, `select` = {0,0,1}. Require all outputs 00 and `valid` = 0.
- Out-of-range field: `select` = {3,1,0} with any data. Require all outputs 00 and `valid` = 0.
- Sweep: for 17 random data triples, including equal triples and all-zero data, step `select` through 0..63 one per clock, then apply 64 random words. Each cycle, compare against the rules above with 1-cycle latency. Require exactly 6 codes per sweep to give `valid` = 1.
